fp_mult_ci_ctrl: RTL and testbench

//  Nios II multi-cycle custom-instruction front end for the pipelined FP32 multiplier (fp_mult_custom).

---
 rtl/fp_mult_ci_ctrl.sv | 119 +++++++++++
 tb/tb_fp_mult_ci_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_ci_ctrl.sv
// Nios II multi-cycle custom-instruction front end for a pipelined FP32 multiplier.
// Latches operands, counts pipeline latency, returns the product with a done pulse.
module fp_mult_ci_ctrl #(
    parameter int LATENCY = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic        busy,
    output logic        pipe_aclr,
    output logic        pipe_clk_en,
    output logic [31:0] pipe_dataa,
    output logic [31:0] pipe_datab,
    input  logic [31:0] pipe_result
);

    localparam logic [4:0] LAT5 = 5'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic [31:0] r_result;
    logic [31:0] r_dataa;
    logic [31:0] r_datab;

    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_zero;
    logic        w_sign;
    logic        w_last;

    assign w_a_zero = (dataa[30:0] == 31'd0);
    assign w_b_zero = (datab[30:0] == 31'd0);
    // a*a only depends on A, so B is not allowed to trigger the early-out
    assign w_zero   = w_a_zero || ((n != 2'd1) && w_b_zero);
    assign w_last   = (r_cnt == LAT5);

    always_comb begin
        w_sign = dataa[31] ^ datab[31];
        unique case (n)
            2'd1:    w_sign = 1'b0;
            2'd2:    w_sign = ~(dataa[31] ^ datab[31]);
            default: w_sign = dataa[31] ^ datab[31];
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
            r_result <= 32'd0;
            r_dataa  <= 32'd0;
            r_datab  <= 32'd0;
        end else if (clk_en) begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (start && w_zero) begin
                        r_result <= {w_sign, 31'd0};
                    end else if (start) begin
                        r_dataa <= dataa;
                        r_datab <= (n == 2'd1) ? dataa : datab;
                        r_neg   <= (n == 2'd2);
                        r_cnt   <= 5'd0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_result <= {pipe_result[31] ^ r_neg,
                                     pipe_result[30:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign result      = r_result;
    assign pipe_aclr   = reset;
    assign pipe_clk_en = (r_state == S_RUN) && clk_en && !reset;
    assign pipe_dataa  = r_dataa;
    assign pipe_datab  = r_datab;

endmodule

// File: tb/tb_fp_mult_ci_ctrl.sv
// Bench for fp_mult_ci_ctrl: behavioural FP32 multiplier pipeline, vector table,
// random operations against a reference model, and stall/reset/overlap sequences.
module tb_fp_mult_ci_ctrl;

    localparam int LAT = 11;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;
    logic        busy;
    logic        pipe_aclr;
    logic        pipe_clk_en;
    logic [31:0] pipe_dataa;
    logic [31:0] pipe_datab;
    logic [31:0] pipe_result;

    int checks = 0;
    int errors = 0;

    fp_mult_ci_ctrl #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .n           (n),
        .dataa       (dataa),
        .datab       (datab),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .pipe_aclr   (pipe_aclr),
        .pipe_clk_en (pipe_clk_en),
        .pipe_dataa  (pipe_dataa),
        .pipe_datab  (pipe_datab),
        .pipe_result (pipe_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout global");
        $fatal(1);
    end

    // FP32 multiply, round to nearest even, normal operands only
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [24:0] m;
        logic        g;
        logic        st;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {1'b0, p[47:24]};
            g = p[23];
            st = |p[22:0];
            e++;
        end else begin
            m = {1'b0, p[46:23]};
            g = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        return {a[31] ^ b[31], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] bb;
        logic        az;
        logic        bz;
        logic        s;
        bb = (op == 2'd1) ? a : b;
        az = (a[30:0] == 31'd0);
        bz = (bb[30:0] == 31'd0);
        s  = a[31] ^ bb[31];
        if (op == 2'd2) s = ~s;
        if (az || bz) return {s, 31'd0};
        return {s, fmul(a, bb) ^ 32'h0 ^ {31'd0, 1'b0}} & 32'h7fffffff
               | {s, 31'd0};
    endfunction

    function automatic bit is_early(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        return (a[30:0] == 31'd0) || (op != 2'd1 && b[30:0] == 31'd0);
    endfunction

    logic [31:0] pipe_q [LAT];
    always @(posedge clk) begin
        if (pipe_aclr) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
        end else if (pipe_clk_en) begin
            pipe_q[0] <= fmul(pipe_dataa, pipe_datab);
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
    assign pipe_result = pipe_q[LAT-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int stall_at, input int stall_len,
                          input int dup_at);
        int cyc;
        int ens;
        bit seen;
        bit busy_bad;
        @(negedge clk);
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
        datab = $urandom;
        cyc = 1;
        ens = 0;
        seen = 1'b0;
        busy_bad = 1'b0;
        while (cyc <= 200) begin
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (pipe_clk_en) ens++;
            if (stall_at != 0 && cyc == stall_at) clk_en = 1'b0;
            if (stall_at != 0 && cyc == stall_at + stall_len) clk_en = 1'b1;
            if (dup_at != 0 && cyc == dup_at) begin
                start = 1'b1;
                n     = 2'd0;
                dataa = 32'h40400000;
                datab = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check({nm, " done_seen"}, 32'(seen), 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        check({nm, " result"}, result, exp_res);
        check({nm, " pipe_en_cycles"}, 32'(ens),
              (exp_lat == 1) ? 32'd0 : 32'(LAT + 1));
        check({nm, " busy"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        check({nm, " done_pulse"}, 32'(done), 32'd0);
        check({nm, " result_hold"}, result, exp_res);
        check({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{2'd0, 32'h3f800000, 32'h40840000, 32'h40840000, LAT + 2};
        tbl[1] = '{2'd0, 32'h42ff8000, 32'h41de0000, 32'h455d9100, LAT + 2};
        tbl[2] = '{2'd1, 32'h45000000, 32'h12345678, 32'h4a800000, LAT + 2};
        tbl[3] = '{2'd2, 32'h3f800000, 32'h40840000, 32'hc0840000, LAT + 2};
        tbl[4] = '{2'd0, 32'h80000000, 32'h40840000, 32'h80000000, 1};
        tbl[5] = '{2'd3, 32'h40000000, 32'h00000000, 32'h00000000, 1};
        tbl[6] = '{2'd2, 32'hbf800000, 32'h80000000, 32'h80000000, 1};
        tbl[7] = '{2'd1, 32'h3f800000, 32'h00000000, 32'h3f800000, LAT + 2};

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd0;
        dataa  = 32'd0;
        datab  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst pipe_en", 32'(pipe_clk_en), 32'd0);
        check("rst pipe_a", pipe_dataa, 32'd0);
        check("rst pipe_b", pipe_datab, 32'd0);
        check("rst aclr", 32'(pipe_aclr), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("aclr low", 32'(pipe_aclr), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].lat, 0, 0, 0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            b  = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            if ($urandom_range(0, 5) == 0) a = {1'($urandom), 31'd0};
            if ($urandom_range(0, 5) == 0) b = {1'($urandom), 31'd0};
            run_op($sformatf("rnd%0d", i), op, a, b, ref_op(op, a, b),
                   is_early(op, a, b) ? 1 : LAT + 2, 0, 0, 0);
        end

        run_op("stall", 2'd0, 32'h42ff8000, 32'h41de0000, 32'h455d9100,
               LAT + 2 + 5, 4, 5, 0);

        run_op("overlap", 2'd0, 32'h42ff8000, 32'h41de0000, 32'h455d9100,
               LAT + 2, 0, 0, 3);

        @(negedge clk);
        start = 1'b1;
        n     = 2'd0;
        dataa = 32'h42ff8000;
        datab = 32'h41de0000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort pipe_en", 32'(pipe_clk_en), 32'd0);
        check("abort pipe_a", pipe_dataa, 32'd0);
        check("abort pipe_b", pipe_datab, 32'd0);
        check("abort aclr", 32'(pipe_aclr), 32'd1);
        reset = 1'b0;
        begin
            int hits;
            hits = 0;
            for (int i = 0; i < LAT + 6; i++) begin
                @(negedge clk);
                if (done || busy) hits++;
            end
            check("abort no_done", 32'(hits), 32'd0);
        end
        run_op("post_reset", 2'd0, 32'h3f800000, 32'h40840000, 32'h40840000,
               LAT + 2, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
